// File: rtl/instr_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_sequencer_if                                            |
// | Purpose  : Bundles the program-load handshake and the instruction        |
// |            output channel of instr_sequencer.                            |
// | Signals  : load_valid/load_data/load_ready - word-by-word program load   |
// |            instr_out/instr_valid/pc_out    - registered issue channel    |
// | Modports : master - program source / CPU side                            |
// |            slave  - the sequencer                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface instr_sequencer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_ready;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic [ADDR_W+1:0] pc_out;

  modport master (
    output load_valid, load_data,
    input  load_ready, instr_out, instr_valid, pc_out
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, instr_out, instr_valid, pc_out
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_sequencer                                               |
// | Purpose  : Program sequencer for the single-cycle CPU. Buffers a program |
// |            loaded word-by-word, then issues one 32-bit instruction per   |
// |            clock with run / pause / single-step / clear control. Cycles  |
// |            that issue nothing present NOP_WORD with instr_valid low.     |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            clear           - pulse: back to IDLE with an empty buffer    |
// |            start/halt/step - execution control pulses                    |
// |            bus (slave)     - load handshake + instruction channel        |
// |            count           - number of words loaded                      |
// |            busy / done     - state is RUN|PAUSED / state is DONE         |
// |            issue_cnt       - issued-word counter (optional feature)      |
// | Macro    : INSTR_SEQ_ISSUE_CNT_EN builds the issue counter; otherwise    |
// |            issue_cnt is tied to zero.                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_sequencer #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic                halt,
  input  logic                step,
  instr_sequencer_if.slave    bus,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic [31:0]         issue_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ADDR_W:0] pc_q;       // one bit wider so pc==DEPTH is representable
  logic [ADDR_W:0] count_q;    // low ADDR_W bits double as the write pointer
  logic [31:0]     mem [DEPTH];

  logic            load_ready_w;
  logic            last_word;
  logic            issue;       // a word is registered onto instr_out this edge
  logic            load_en;
  logic            run_restart; // start accepted from IDLE or DONE: pc back to 0

  assign load_ready_w = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign last_word    = (pc_q == (count_q - ONE_C));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode. Strict priority clear > halt > start > step:
  // a higher-priority pulse masks lower ones even when it has no effect itself
  // in the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    load_en     = 1'b0;
    run_restart = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load_en = bus.load_valid && load_ready_w;
          if (!halt && start && (count_q != '0)) begin
            state_d     = ST_RUN;
            run_restart = 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_d = ST_PAUSED;
          end else begin
            issue = 1'b1;
            if (last_word) state_d = ST_DONE;
          end
        end
        ST_PAUSED: begin
          if (halt) begin
            state_d = ST_PAUSED;
          end else if (start) begin
            // Resume from the current pc; the first word appears one edge later.
            state_d = ST_RUN;
          end else if (step) begin
            issue = 1'b1;
            if (last_word) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!halt && start) begin
            state_d     = ST_RUN;
            run_restart = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer write port (IDLE only, so never collides with reads).
  // Contents are intentionally not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[count_q[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: pc, load count and the registered issue channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= '0;
      count_q         <= '0;
      bus.instr_out   <= NOP_WORD;
      bus.instr_valid <= 1'b0;
      bus.pc_out      <= '0;
    end else begin
      if (clear || run_restart) begin
        pc_q <= '0;
      end else if (issue) begin
        pc_q <= pc_q + ONE_C;
      end

      if (clear) begin
        count_q <= '0;
      end else if (load_en) begin
        count_q <= count_q + ONE_C;
      end

      // pc_out keeps its last value on non-issue cycles.
      if (issue) begin
        bus.instr_out   <= mem[pc_q[ADDR_W-1:0]];
        bus.instr_valid <= 1'b1;
        bus.pc_out      <= {pc_q[ADDR_W-1:0], 2'b00};
      end else begin
        bus.instr_out   <= NOP_WORD;
        bus.instr_valid <= 1'b0;
      end
    end
  end

  assign bus.load_ready = load_ready_w;
  assign count          = count_q;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done           = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Optional issued-word counter. Counts issue edges, so it matches the number
  // of valid cycles presented so far; cleared on any fresh run but kept across
  // a pause/resume.
  // ---------------------------------------------------------------------------
`ifdef INSTR_SEQ_ISSUE_CNT_EN
  logic [31:0] issue_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear || run_restart) begin
      issue_cnt_q <= '0;
    end else if (issue && (issue_cnt_q != 32'hFFFF_FFFF)) begin
      issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
`else
  assign issue_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer for the single-cycle CPU: buffers a program loaded word-by-word, then drives the CPU's 32-bit Instruction input one word per clock.
- Replaces bench-driven instruction application.
- Supports run, pause, single-step and clear.
- Non-issue cycles present a NOP, so the datapath never executes stale words.

Parameters:
- DEPTH, 128, instruction buffer entries (32-bit words).
- ADDR_W, 7, index width; DEPTH == 2**ADDR_W.
- NOP_WORD, 32'h00000000, word driven on instr_out when instr_valid=0.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  pulse: return to IDLE, empty buffer (wr_ptr=0, pc=0); buffer contents are not erased.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  32  instruction word to append.
- load_ready  out  1  buffer accepts a word this cycle.
- start  in  1  pulse: begin/resume/restart execution.
- halt  in  1  pulse: pause execution.
- step  in  1  pulse: issue one instruction while paused.
- instr_out  out  32  instruction to CPU (registered).
- instr_valid  out  1  instr_out is a real program word.
- pc_out  out  ADDR_W+2  byte address of instr_out (index*4).
- count  out  ADDR_W+1  number of words loaded.
- busy  out  1  state is RUN or PAUSED.
- done  out  1  state is DONE.
- issue_cnt  out  32  see Optional Feature.

Behaviour:
- Reset:
  - state=IDLE; wr_ptr=0; pc=0.
  - instr_out=NOP_WORD; instr_valid=0; pc_out=0; count=0; busy=0; done=0; issue_cnt=0.
  - load_ready=1 after reset.
- States: IDLE, RUN, PAUSED, DONE.
- Control priority, same cycle: rst > clear > halt > start > step. Lower-priority pulses in that cycle are ignored.
- Load:
  - Accepted only in IDLE.
  - load_ready = (state==IDLE) && (count<DEPTH).
  - On load_valid && load_ready: mem[wr_ptr]<=load_data, wr_ptr++, count++.
  - count==DEPTH: load_ready=0; further load_valid is dropped and count holds.
  - load_valid outside IDLE is ignored.
- IDLE:
  - start with count>0: pc<=0, go to RUN.
  - start with count==0: ignored.
  - step in IDLE: ignored.
- RUN:
  - Each cycle register instr_out<=mem[pc], pc_out<=pc*4, instr_valid<=1, pc++.
  - Latency: start sampled at edge N; word 0 is visible after edge N+1; word k after edge N+1+k.
  - When the word at index count-1 issues, go to DONE; next cycle instr_valid=0.
  - halt: go to PAUSED. No word issues on that edge; pc holds.
- PAUSED:
  - Each step pulse issues exactly one word (same registering as RUN), pc++.
  - If the word issued is index count-1, go to DONE.
  - start: go to RUN from the current pc.
  - step held high for several cycles issues one word per cycle.
- DONE:
  - done=1; pc holds at count.
  - start: pc<=0, go to RUN (re-execute same program).
  - clear: go to IDLE.
- Any cycle with no issue: instr_out=NOP_WORD, instr_valid=0, pc_out holds its last value.
- clear mid-RUN/PAUSED:
  - Next cycle: IDLE, instr_valid=0, count=0, load_ready=1.
  - The word in flight that cycle is not issued.
- rst mid-operation: identical to reset values above; buffer contents are don't-care.
- Memory: inferred synchronous RAM. The write port is used only in IDLE and the read port only in RUN/PAUSED, so there is no read/write collision.
- Width rules: pc is ADDR_W+1 bits so that pc==DEPTH is representable. pc_out = {pc[ADDR_W-1:0], 2'b00}.

Optional Feature:
- Macro: INSTR_SEQ_ISSUE_CNT_EN.
- Defined:
  - issue_cnt increments on every cycle with instr_valid=1.
  - Saturates at 32'hFFFFFFFF.
  - Resets to 0 on rst, on clear, and on start from IDLE or DONE.
  - Does not reset on resume from PAUSED.
- Undefined: counter logic is not built; issue_cnt is tied to 32'h0. Port list is unchanged.

Test Plan:
- Load 3 words 0x04A94020, 0x05495820, 0x10090004, then pulse start -> instr_valid high for exactly 3 cycles, presenting those words with pc_out 0x000/0x004/0x008. done=1 on the following cycle; instr_out=0x00000000 afterwards.
- Load 5 words, start, pulse halt at second issue cycle -> exactly 2 words issued, busy=1, instr_valid=0. Three step pulses issue words 2, 3, 4 one at a time; done=1 after word 4.
- Load DEPTH=128 words plus one extra with load_valid -> count=128, load_ready=0 from the cycle after the 128th accept, extra word dropped. Run issues 128 words; last pc_out=0x1FC.
- Start with count==0 -> remains IDLE, instr_valid never asserts. Same cycle halt+start in RUN -> PAUSED, no issue.
- clear during RUN at word 1 of 4 -> next cycle IDLE, count=0, instr_valid=0, load_ready=1. Reload 2 words and start -> only the new 2 words issue.
- With INSTR_SEQ_ISSUE_CNT_EN: run 4 words, halt/resume once -> issue_cnt=4 at DONE. Restart -> issue_cnt returns to 0 then 4. Without the macro -> issue_cnt=0 throughout.
